// File: rtl/call_request_serializer.sv
// Call-button front-end for the lift controller: synchronizes and debounces the floor buttons,
// latches accepted calls and presents them one at a time on req_floor.
module call_request_serializer #(
   parameter int unsigned NUM_FLOORS      = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned HOLD_CYCLES     = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] btn,
   input  logic [2:0]            current_floor,
   input  logic                  door,
   input  logic                  emergency_stop,
   output logic [2:0]            req_floor,
   output logic                  req_strobe,
   output logic [NUM_FLOORS-1:0] pending,
   output logic [NUM_FLOORS-1:0] outstanding,
   output logic                  busy
);

   localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

   localparam logic [CntW-1:0]  DbMax    = CntW'(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0]  DbPre    = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HoldW-1:0] HoldInit = HoldW'(HOLD_CYCLES);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StHold
   } state_e;

   state_e                  state_q, state_d;
   logic [NUM_FLOORS-1:0]   btn_meta_q, btn_sync_q;
   logic [CntW-1:0]         cnt_q [NUM_FLOORS];
   logic [CntW-1:0]         cnt_d [NUM_FLOORS];
   logic [NUM_FLOORS-1:0]   accept;
   logic [NUM_FLOORS-1:0]   served;
   logic [NUM_FLOORS-1:0]   pending_q, pending_d;
   logic [NUM_FLOORS-1:0]   outstanding_q, outstanding_d;
   logic [NUM_FLOORS-1:0]   skip_mask;
   logic [NUM_FLOORS-1:0]   cand;
   logic [2:0]              last_issued_q, last_issued_d;
   logic [2:0]              sel_q, sel_d;
   logic [2:0]              sel_floor;
   logic [2:0]              scan;
   logic                    sel_found;
   logic [HoldW-1:0]        hold_q, hold_d;
   logic [2:0]              req_floor_q, req_floor_d;
   logic                    req_strobe_q, req_strobe_d;
   logic                    issue;

   // Two-flop synchronizer on the raw buttons
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_meta_q <= '0;
         btn_sync_q <= '0;
      end else begin
         btn_meta_q <= btn;
         btn_sync_q <= btn_meta_q;
      end
   end

   // Accept fires on the edge where the counter steps from DbPre to DbMax, so once per press
   always_comb begin
      accept = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (!btn_sync_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] != DbMax) begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
         end
         accept[i] = btn_sync_q[i] && (cnt_q[i] == DbPre);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_FLOORS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_FLOORS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign served = door ? (NUM_FLOORS'(1) << current_floor) : '0;

   // The lift only reacts to a change on req_floor, so re-issuing last_issued is pointless
   // unless it is still outstanding.
   assign skip_mask = (NUM_FLOORS'(1) << last_issued_q) & ~outstanding_q;
   assign cand      = pending_q & ~skip_mask;

   always_comb begin
      sel_found = 1'b0;
      sel_floor = '0;
      scan      = '0;
      for (int i = 1; i <= 8; i++) begin
         scan = current_floor + 3'(i);
         if (!sel_found && cand[scan]) begin
            sel_found = 1'b1;
            sel_floor = scan;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      hold_d        = hold_q;
      req_floor_d   = req_floor_q;
      req_strobe_d  = 1'b0;
      last_issued_d = last_issued_q;
      issue         = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!emergency_stop && sel_found) begin
               sel_d   = sel_floor;
               state_d = StIssue;
            end
         end
         StIssue: begin
            req_floor_d   = sel_q;
            req_strobe_d  = 1'b1;
            last_issued_d = sel_q;
            hold_d        = HoldInit;
            issue         = 1'b1;
            state_d       = StHold;
         end
         StHold: begin
            hold_d = hold_q - HoldW'(1);
            if (hold_q == HoldW'(1)) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Served beats a same-cycle accept, and also beats the outstanding set from an issue
   always_comb begin
      pending_d     = pending_q | (accept & ~outstanding_q & ~served);
      outstanding_d = outstanding_q;
      if (issue) begin
         pending_d[sel_q]     = 1'b0;
         outstanding_d[sel_q] = 1'b1;
      end
      outstanding_d = outstanding_d & ~served;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         sel_q         <= '0;
         hold_q        <= '0;
         req_floor_q   <= '0;
         req_strobe_q  <= 1'b0;
         last_issued_q <= '0;
         pending_q     <= '0;
         outstanding_q <= '0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         hold_q        <= hold_d;
         req_floor_q   <= req_floor_d;
         req_strobe_q  <= req_strobe_d;
         last_issued_q <= last_issued_d;
         pending_q     <= pending_d;
         outstanding_q <= outstanding_d;
      end
   end

   assign req_floor   = req_floor_q;
   assign req_strobe  = req_strobe_q;
   assign pending     = pending_q;
   assign outstanding = outstanding_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_call_request_serializer.sv
// Scoreboard bench for call_request_serializer: expected floors are queued when calls are
// pressed and popped on every req_strobe.
module tb_call_request_serializer;

   logic       clk;
   logic       reset;
   logic [7:0] btn;
   logic [2:0] current_floor;
   logic       door;
   logic       emergency_stop;
   logic [2:0] req_floor;
   logic       req_strobe;
   logic [7:0] pending;
   logic [7:0] outstanding;
   logic       busy;

   int         total;
   int         bad;
   int         cyc;
   logic [2:0] exp_q [$];
   int         strobe_cycs [$];

   call_request_serializer dut (
      .clk            (clk),
      .reset          (reset),
      .btn            (btn),
      .current_floor  (current_floor),
      .door           (door),
      .emergency_stop (emergency_stop),
      .req_floor      (req_floor),
      .req_strobe     (req_strobe),
      .pending        (pending),
      .outstanding    (outstanding),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [7:0] mask, input int n);
      btn = mask;
      tick(n);
      btn = '0;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      check_val(tag, exp_q.size(), 0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (reset && req_strobe) begin
         strobe_cycs.push_back(cyc);
         check_val("strobe_expected", int'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            check_val("strobe_floor", req_floor, exp_q.pop_front());
         end
         check_val("strobe_busy", busy, 1);
      end
   end

   int c0;
   int b0;
   int n0;
   int k;

   initial begin
      total          = 0;
      bad            = 0;
      reset          = 1'b0;
      btn            = '0;
      current_floor  = '0;
      door           = 1'b0;
      emergency_stop = 1'b0;
      tick(3);
      check_val("rst_req_floor", req_floor, 0);
      check_val("rst_strobe", req_strobe, 0);
      check_val("rst_pending", pending, 0);
      check_val("rst_outstanding", outstanding, 0);
      check_val("rst_busy", busy, 0);
      reset = 1'b1;
      tick(2);

      // Three calls accepted together from floor 4: scan order gives 6, 1, 2
      current_floor = 3'd4;
      exp_q.push_back(3'd6);
      exp_q.push_back(3'd1);
      exp_q.push_back(3'd2);
      b0 = strobe_cycs.size();
      press(8'h46, 25);
      wait_drain("order_drain", 60);
      check_val("order_count", strobe_cycs.size() - b0, 3);
      if (strobe_cycs.size() >= b0 + 3) begin
         check_val("spacing_1", strobe_cycs[b0+1] - strobe_cycs[b0], 6);
         check_val("spacing_2", strobe_cycs[b0+2] - strobe_cycs[b0+1], 6);
      end
      check_val("order_pending", pending, 8'h00);
      check_val("order_outstanding", outstanding, 8'h46);

      // Serve floors 1, 2, 6
      door = 1'b1;
      current_floor = 3'd1; tick(1);
      current_floor = 3'd2; tick(1);
      current_floor = 3'd6; tick(1);
      door = 1'b0;
      current_floor = 3'd0;
      tick(1);
      check_val("served_clear", outstanding, 8'h00);

      // Single press latency
      exp_q.push_back(3'd5);
      c0 = cyc;
      b0 = strobe_cycs.size();
      press(8'h20, 40);
      tick(5);
      wait_drain("lat_drain", 20);
      check_val("lat_count", strobe_cycs.size() - b0, 1);
      if (strobe_cycs.size() > b0) begin
         check_val("lat_cycle", strobe_cycs[b0] - c0, 20);
      end
      check_val("lat_req_floor", req_floor, 5);
      check_val("lat_outstanding", outstanding, 8'h20);
      check_val("lat_pending", pending, 8'h00);

      // Glitch shorter than the debounce window
      b0 = strobe_cycs.size();
      press(8'h08, 10);
      tick(30);
      check_val("glitch_pending", pending, 8'h00);
      check_val("glitch_no_strobe", strobe_cycs.size() - b0, 0);

      // Duplicate of an outstanding call
      current_floor = 3'd2;
      press(8'h20, 25);
      tick(5);
      check_val("dup_pending", pending, 8'h00);
      current_floor = 3'd5;
      door = 1'b1;
      tick(2);
      door = 1'b0;
      current_floor = 3'd2;
      tick(1);
      check_val("serve5_outstanding", outstanding, 8'h00);

      // Same floor as last issued and not outstanding: latched but skipped
      b0 = strobe_cycs.size();
      press(8'h20, 25);
      tick(10);
      check_val("skip_pending", pending, 8'h20);
      check_val("skip_no_strobe", strobe_cycs.size() - b0, 0);
      exp_q.push_back(3'd0);
      exp_q.push_back(3'd5);
      press(8'h01, 25);
      wait_drain("skip_drain", 60);
      check_val("skip_pending_after", pending, 8'h00);
      check_val("skip_outstanding", outstanding, 8'h21);

      // Emergency stop latches but does not issue
      emergency_stop = 1'b1;
      b0 = strobe_cycs.size();
      press(8'h80, 25);
      tick(10);
      check_val("emg_pending", pending, 8'h80);
      check_val("emg_no_strobe", strobe_cycs.size() - b0, 0);
      exp_q.push_back(3'd7);
      emergency_stop = 1'b0;
      tick(2);
      check_val("emg_resume_strobe", req_strobe, 1);
      check_val("emg_resume_floor", req_floor, 7);
      wait_drain("emg_drain", 10);
      check_val("emg_outstanding", outstanding, 8'hA1);

      // Reset in the middle of HOLD with calls still pending
      current_floor = 3'd3;
      exp_q.push_back(3'd4);
      n0 = strobe_cycs.size();
      btn = 8'h1C;
      k = 0;
      while (strobe_cycs.size() == n0 && k < 60) begin
         @(negedge clk);
         k++;
      end
      check_val("rh_strobe_seen", int'(strobe_cycs.size() > n0), 1);
      @(posedge clk);
      #2;
      check_val("rh_pending", pending, 8'h0C);
      check_val("rh_busy", busy, 1);
      reset = 1'b0;
      btn   = '0;
      #1;
      check_val("rh_req_floor", req_floor, 0);
      check_val("rh_strobe", req_strobe, 0);
      check_val("rh_pending_clr", pending, 0);
      check_val("rh_outstanding_clr", outstanding, 0);
      check_val("rh_busy_clr", busy, 0);
      tick(3);
      #2;
      reset = 1'b1;
      b0 = strobe_cycs.size();
      tick(40);
      check_val("post_rst_no_strobe", strobe_cycs.size() - b0, 0);
      check_val("post_rst_pending", pending, 8'h00);
      check_val("final_queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
